// File: rtl/ahci_dma_rd_unpack.sv
`default_nettype none
//============================================================================
// Module  : ahci_dma_rd_unpack
// Purpose : AHCI DMA read path, upstream of the DWORD stuffer. Takes the
//           64-bit memory qwords of one PRD segment, splits each qword into
//           two dwords with 2-bit 16-bit-word masks, drops dwords that carry
//           no valid word, queues the rest in a small FIFO and pulses flush
//           once the segment has drained.
// Ports   : clk, rst_n (async, active low)
//           start/start_word/nwords/abort : segment control
//           din64/din64_vld/din64_re     : qword input handshake
//           dout/dm/dout_av/dout_avm/dout_re : stuffer-side dword interface
//           flush, busy, done            : segment status
//           stat_qwords/stat_dwords      : only with AHCI_DMA_RD_UNPACK_STAT_EN
// Config  : `define AHCI_DMA_RD_UNPACK_STAT_EN adds the statistics counters.
// Revision: 1.0 - initial release
//============================================================================
module ahci_dma_rd_unpack #(
  parameter int WCNT_W    = 22,
  parameter int FIFO_LOG2 = 2,
  parameter int FLUSH_DLY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        start_word,
  input  logic [WCNT_W-1:0] nwords,
  input  logic              abort,
  input  logic [63:0]       din64,
  input  logic              din64_vld,
  output logic              din64_re,
  output logic [31:0]       dout,
  output logic [1:0]        dm,
  output logic              dout_av,
  output logic              dout_avm,
  input  logic              dout_re,
  output logic              flush,
  output logic              busy,
`ifdef AHCI_DMA_RD_UNPACK_STAT_EN
  output logic [WCNT_W-1:0] stat_qwords,
  output logic [WCNT_W-1:0] stat_dwords,
`endif
  output logic              done
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int DLY_W = (FLUSH_DLY > 1) ? $clog2(FLUSH_DLY + 1) : 1;
  localparam logic [FIFO_LOG2+1:0] DEPTH_W = (FIFO_LOG2+2)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    FLUSHW = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Segment bookkeeping
  logic [1:0]        s_q;       // first valid word index
  logic [WCNT_W:0]   end_q;     // s + n, one past the last valid word
  logic [WCNT_W-1:0] qleft;     // qwords still to fetch
  logic [WCNT_W-1:0] qidx;      // index of the qword currently offered
  logic [DLY_W-1:0]  dly_cnt;

  // Dword FIFO
  logic [31:0]          mem_d [DEPTH];
  logic [1:0]           mem_m [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr, wr_hi;
  logic [FIFO_LOG2:0]   count, count_nxt;
  logic                 av_q, avm_q;

  logic                 abort_act;
  logic                 start_acc;
  logic                 pop;
  logic                 accept;
  logic                 push_lo, push_hi;
  logic [FIFO_LOG2+1:0] free;
  logic [3:0]           wv;
  logic [WCNT_W:0]      sum_w;
  logic [WCNT_W-1:0]    qtot;

  assign abort_act = abort && (state != IDLE);
  assign start_acc = (state == IDLE) && start && !abort;

  // ceil((s+n)/4): s+n needs WCNT_W+1 bits, the quotient fits in WCNT_W
  assign sum_w = {1'b0, nwords} + {{(WCNT_W-1){1'b0}}, start_word};
  assign qtot  = {1'b0, sum_w[WCNT_W:2]} + {{(WCNT_W-1){1'b0}}, |sum_w[1:0]};

  assign pop = dout_re && av_q;

  // Free slots after this cycle's pop; a qword may push two dwords
  assign free = DEPTH_W - {1'b0, count} + {{(FIFO_LOG2+1){1'b0}}, pop};

  assign din64_re = (state == RUN) && (qleft != '0) && (free >= (FIFO_LOG2+2)'(2));
  assign accept   = din64_re && din64_vld && !abort_act;

  // Word k of the current qword sits at global position 4*qidx+k
  for (genvar k = 0; k < 4; k++) begin : g_word
    logic [WCNT_W+1:0] pos;
    assign pos   = {qidx, 2'(k)};
    assign wv[k] = (pos >= {{WCNT_W{1'b0}}, s_q}) && (pos < {1'b0, end_q});
  end

  assign push_lo = accept && (wv[1:0] != 2'b00);
  assign push_hi = accept && (wv[3:2] != 2'b00);
  // The high dword takes the slot after the low one only if the low one was kept
  assign wr_hi   = wr_ptr + FIFO_LOG2'(push_lo);

  assign count_nxt = count + (FIFO_LOG2+1)'(push_lo) + (FIFO_LOG2+1)'(push_hi)
                   - (FIFO_LOG2+1)'(pop);

  // FIFO storage: contents need no reset, the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_lo) begin
      mem_d[wr_ptr] <= din64[31:0];
      mem_m[wr_ptr] <= wv[1:0];
    end
    if (push_hi) begin
      mem_d[wr_hi] <= din64[63:32];
      mem_m[wr_hi] <= wv[3:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      av_q   <= 1'b0;
      avm_q  <= 1'b0;
    end else if (abort_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      av_q   <= 1'b0;
      avm_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_LOG2'(push_lo) + FIFO_LOG2'(push_hi);
      rd_ptr <= rd_ptr + FIFO_LOG2'(pop);
      count  <= count_nxt;
      av_q   <= (count_nxt != '0);
      avm_q  <= (count_nxt > (FIFO_LOG2+1)'(1));
    end
  end

  assign dout_av  = av_q;
  assign dout_avm = avm_q;
  assign dout     = av_q ? mem_d[rd_ptr] : 32'h0;
  assign dm       = av_q ? mem_m[rd_ptr] : 2'b00;

  // Segment registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= 2'b00;
      end_q <= '0;
      qleft <= '0;
      qidx  <= '0;
    end else if (start_acc) begin
      s_q   <= start_word;
      end_q <= sum_w;
      qleft <= qtot;
      qidx  <= '0;
    end else if (abort_act) begin
      qleft <= '0;
    end else if (accept) begin
      qleft <= qleft - 1'b1;
      qidx  <= qidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if (state == FLUSHW) begin
      dly_cnt <= dly_cnt + 1'b1;
    end else begin
      dly_cnt <= '0;
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    done      = 1'b0;
    if (abort_act) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_acc) begin
            state_nxt = (nwords == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (accept && (qleft == WCNT_W'(1))) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the FIFO is empty after this cycle's pop, so the
          // flush delay counts from the first cycle the FIFO reads empty
          if (count_nxt == '0) begin
            state_nxt = FLUSHW;
          end
        end
        FLUSHW: begin
          if (dly_cnt == DLY_W'(FLUSH_DLY)) begin
            flush     = 1'b1;
            state_nxt = FIN;
          end
        end
        FIN: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DRAIN) || (state == FLUSHW);

`ifdef AHCI_DMA_RD_UNPACK_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_qwords <= '0;
      stat_dwords <= '0;
    end else if (start_acc) begin
      stat_qwords <= '0;
      stat_dwords <= '0;
    end else begin
      if (accept) begin
        stat_qwords <= stat_qwords + 1'b1;
      end
      stat_dwords <= stat_dwords + WCNT_W'(push_lo) + WCNT_W'(push_hi);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/ahci_dma_rd_unpack.md
Name: ahci_dma_rd_unpack

Overview:
- Upstream neighbour of the DWORD stuffer in the AHCI DMA read path.
- Accepts 64-bit memory read data (qwords) for one PRD segment.
- Splits each qword into two 32-bit dwords, each with a 2-bit 16-bit-word mask marking valid words, and presents them on the stuffer's din/dm/din_av/din_avm/din_re interface.
- Drops all-invalid dwords, then pulses flush after the segment drains so the stuffer emits any partial dword.

Parameters:
WCNT_W, 22, width of the 16-bit-word count (covers a 4 MiB PRD)
FIFO_LOG2, 2, log2 depth of the output dword FIFO (default 4 entries; minimum 2)
FLUSH_DLY, 2, cycles from FIFO empty after the last dword pop to the flush pulse

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous reset, active low
start  in  1  one-cycle pulse; latches start_word/nwords; ignored while busy
start_word  in  2  index of the first valid 16-bit word in the first qword
nwords  in  WCNT_W  number of 16-bit words to deliver
abort  in  1  synchronous abort; drops the segment
din64  in  64  memory qword; word k = din64[16k+15:16k]
din64_vld  in  1  qword available
din64_re  out  1  qword accepted when din64_vld && din64_re
dout  out  32  dword to the stuffer (its din)
dm  out  2  dm[0] marks dout[15:0] valid, dm[1] marks dout[31:16] valid
dout_av  out  1  FIFO not empty
dout_avm  out  1  FIFO holds more than 1 entry
dout_re  in  1  pop request; ignored when !dout_av
flush  out  1  one-cycle pulse at end of segment
busy  out  1  segment in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; state IDLE.
  - din64_re, dout_av, dout_avm, flush, busy and done all 0.
  - dout and dm 0.
- States: IDLE, RUN, DRAIN, FLUSHW, FIN.
- IDLE, on start:
  - Latch s = start_word and n = nwords.
  - qwords_left = ceil((s+n)/4), computed at WCNT_W+1 bits with no overflow.
  - If n==0: go to FIN (done pulses the next cycle; no din64_re, no flush).
  - Otherwise: go to RUN and raise busy on the next cycle.
- RUN:
  - din64_re = (qwords_left != 0) && (free FIFO entries >= 2), with free entries counted after this cycle's pop.
  - On an accepted qword with index q, global word position p = 4q+k is valid iff s <= p < s+n.
  - Low dword = words 0,1 with mask {v1,v0}; high dword = words 2,3 with mask {v3,v2}.
  - Each dword with a nonzero mask is pushed in order, low dword first. Zero or two pushes may occur in one cycle.
  - Pop and push in the same cycle are legal; count updates by pushes minus pops.
  - When the last qword is accepted, go to DRAIN.
- DRAIN: wait for FIFO empty, then go to FLUSHW.
- FLUSHW:
  - Wait FLUSH_DLY cycles, then assert flush for one cycle and go to FIN.
  - With FLUSH_DLY = 0, flush is asserted in the first FLUSHW cycle.
- FIN: done = 1 for one cycle, busy drops, return to IDLE.
- Output timing:
  - dout and dm are the FIFO head, combinational from the registered FIFO.
  - dout_av and dout_avm are registered, valid the same cycle as the head.
  - A pushed dword is visible 1 cycle after its qword is accepted.
- abort, any state other than IDLE:
  - Next cycle: FIFO cleared, IDLE, busy 0, din64_re 0.
  - No flush, no done.
  - abort outranks start in the same cycle.
- start while busy is ignored. start and abort in IDLE together: abort wins, start is ignored.

Optional Feature:
- Macro: AHCI_DMA_RD_UNPACK_STAT_EN.
- Defined:
  - Adds output stat_qwords [WCNT_W-1:0], the qwords accepted in the current or last segment.
  - Adds output stat_dwords [WCNT_W-1:0], the dwords pushed.
  - Both clear on an accepted start, hold after done or abort, and reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- start_word=0, nwords=8, din64_vld=1, dout_re=1 -> exactly 2 qwords read; 4 dwords, all dm=11, in order; flush FLUSH_DLY cycles after the FIFO empties; done 1 cycle after flush.
- start_word=1, nwords=4 -> 2 qwords read; dwords with dm=10, then 11, then 01; the high dword of qword 1 (dm=00) is never presented; 3 pops in total.
- nwords=0 -> done 1 cycle after start; din64_re never asserted; no flush.
- start_word=0, nwords=64, dout_re=0 for 20 cycles -> FIFO fills to 4 with dout_avm=1 and din64_re=0; after release, all 32 dwords arrive in order with none lost or duplicated.
- abort after 3 qwords of a 16-qword segment -> next cycle busy=0 and dout_av=0; no flush, no done; a following start/nwords=4 completes normally.
- rst_n low for 1 cycle in mid-RUN -> all outputs 0 immediately, without waiting for a clock edge; the block accepts start after rst_n rises. With the macro defined, the stat counters read 0 after reset.
